// File: rtl/speech_pkg.sv
// Shared speech definitions: allophone codes, ROM entry layout, sequencer
// states, and the constant phrase tables used by phrase_sequencer.
package speech_pkg;

   localparam logic [5:0] PA1 = 6'h00;
   localparam logic [5:0] PA2 = 6'h01;
   localparam logic [5:0] PA3 = 6'h02;
   localparam logic [5:0] PA4 = 6'h03;
   localparam logic [5:0] PA5 = 6'h04;
   localparam logic [5:0] AY  = 6'h06;
   localparam logic [5:0] EH  = 6'h07;
   localparam logic [5:0] NN1 = 6'h0B;
   localparam logic [5:0] TT2 = 6'h0D;
   localparam logic [5:0] RR1 = 6'h0E;
   localparam logic [5:0] AX  = 6'h0F;
   localparam logic [5:0] IY  = 6'h13;
   localparam logic [5:0] AO  = 6'h17;
   localparam logic [5:0] HH1 = 6'h1B;
   localparam logic [5:0] TH  = 6'h1D;
   localparam logic [5:0] UW2 = 6'h1F;
   localparam logic [5:0] VV  = 6'h23;
   localparam logic [5:0] FF  = 6'h28;
   localparam logic [5:0] LL  = 6'h2D;
   localparam logic [5:0] WW  = 6'h2E;
   localparam logic [5:0] ER1 = 6'h33;
   localparam logic [5:0] OW  = 6'h35;
   localparam logic [5:0] SS  = 6'h37;

   localparam int LAST_BIT = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } seq_state_t;

   function automatic int unsigned phrase_start(input int unsigned id);
      case (id)
         0:       return 0;
         1:       return 3;
         2:       return 7;
         3:       return 11;
         4:       return 14;
         5:       return 16;
         6:       return 19;
         7:       return 22;
         default: return 0;
      endcase
   endfunction

   // Unused addresses hold a terminating pause so a stray walk always ends.
   function automatic logic [6:0] rom_entry(input int unsigned addr);
      logic [6:0] e;
      case (addr)
         0:       e = {1'b0, IY};
         1:       e = {1'b0, PA3};
         2:       e = {1'b1, IY};
         3:       e = {1'b0, HH1};
         4:       e = {1'b0, EH};
         5:       e = {1'b0, LL};
         6:       e = {1'b1, OW};
         7:       e = {1'b0, SS};
         8:       e = {1'b0, EH};
         9:       e = {1'b0, VV};
         10:      e = {1'b1, PA2};
         11:      e = {1'b0, WW};
         12:      e = {1'b0, AX};
         13:      e = {1'b1, NN1};
         14:      e = {1'b0, TT2};
         15:      e = {1'b1, UW2};
         16:      e = {1'b0, TH};
         17:      e = {1'b0, RR1};
         18:      e = {1'b1, IY};
         19:      e = {1'b0, FF};
         20:      e = {1'b0, AO};
         21:      e = {1'b1, ER1};
         22:      e = {1'b0, FF};
         23:      e = {1'b0, AY};
         24:      e = {1'b1, VV};
         default: e = {1'b1, PA1};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/phrase_fifo.sv
// Small synchronous FIFO holding pending phrase IDs; show-ahead read port.
module phrase_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/phrase_sequencer.sv
// Queues phrase requests and streams each phrase's allophones from ROM to the
// chatter speech block over its data/write/busy handshake.
module phrase_sequencer
   import speech_pkg::*;
#(
   parameter int NUM_PHRASES = 8,
   parameter int ROM_DEPTH   = 64,
   parameter int QUEUE_DEPTH = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   input  logic [$clog2(NUM_PHRASES)-1:0] req_phrase,
   output logic                           req_ready,
   output logic [5:0]                     data,
   output logic                           write,
   input  logic                           busy,
   output logic                           active,
   output logic                           phrase_done,
   output logic                           overflow
);

   localparam int ID_W = $clog2(NUM_PHRASES);
   localparam int AW   = $clog2(ROM_DEPTH);
   localparam int CW   = $clog2(ACK_TIMEOUT + 1);

   seq_state_t      state;
   seq_state_t      state_nxt;
   logic [AW-1:0]   addr;
   logic [6:0]      rom_q;
   logic [CW-1:0]   ack_cnt;
   logic            write_q;
   logic            done_q;
   logic            overflow_q;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic [ID_W-1:0] fifo_dout;
   logic            issue_wr;
   logic            finish;
   logic            advance;

   assign push = req_valid && !fifo_full;

   phrase_fifo #(
      .WIDTH (ID_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (req_phrase),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      issue_wr  = 1'b0;
      finish    = 1'b0;
      advance   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (!busy) begin
               issue_wr  = 1'b1;
               state_nxt = S_WAIT_ACK;
            end
         end
         // A chatter that never acknowledges is assumed to have taken the write.
         S_WAIT_ACK: begin
            if (busy || ack_cnt == CW'(ACK_TIMEOUT - 1)) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!busy) begin
               if (rom_q[LAST_BIT]) begin
                  finish    = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  advance   = 1'b1;
                  state_nxt = S_FETCH;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // rom_q only loads in FETCH, so data stays put until the next allophone fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         rom_q      <= '0;
         ack_cnt    <= '0;
         write_q    <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         write_q <= issue_wr;
         done_q  <= finish;
         if (req_valid && fifo_full) overflow_q <= 1'b1;
         if (pop) begin
            addr <= AW'(phrase_start(32'(fifo_dout)));
         end else if (advance) begin
            addr <= (addr == AW'(ROM_DEPTH - 1)) ? '0 : addr + AW'(1);
         end
         if (state == S_FETCH) rom_q <= rom_entry(32'(addr));
         if (state == S_WAIT_ACK) ack_cnt <= ack_cnt + CW'(1);
         else                     ack_cnt <= '0;
      end
   end

   assign req_ready   = !fifo_full;
   assign data        = rom_q[5:0];
   assign write       = write_q;
   assign active      = (state != S_IDLE);
   assign phrase_done = done_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_phrase_sequencer.sv
// Directed bench for phrase_sequencer with a behavioural chatter busy model.
module tb_phrase_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic [2:0] req_phrase;
   logic       req_ready;
   logic [5:0] data;
   logic       write;
   logic       busy = 1'b0;
   logic       active;
   logic       phrase_done;
   logic       overflow;

   int         n_vec  = 0;
   int         n_miss = 0;
   int         ncyc   = 0;
   int         hold   = 0;
   int         rel;
   logic       busy_force;
   logic       model_en;

   logic [5:0] wdat[$];
   int         wcyc[$];
   int         dcyc[$];
   logic [5:0] exp_q[$];

   phrase_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_phrase  (req_phrase),
      .req_ready   (req_ready),
      .data        (data),
      .write       (write),
      .busy        (busy),
      .active      (active),
      .phrase_done (phrase_done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Chatter model and output monitor run on the falling edge.
   always @(negedge clk) begin
      ncyc++;
      if (write) begin
         wdat.push_back(data);
         wcyc.push_back(ncyc);
      end
      if (phrase_done) dcyc.push_back(ncyc);
      if (model_en && write) hold = 10;
      else if (hold > 0)     hold--;
      busy = busy_force || (hold > 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_miss++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic request(input int id);
      req_valid  = 1'b1;
      req_phrase = 3'(id);
      tick(1);
      req_valid  = 1'b0;
   endtask

   task automatic clear_logs();
      wdat.delete();
      wcyc.delete();
      dcyc.delete();
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      int k = 0;
      while (dcyc.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk(tag, dcyc.size(), n);
   endtask

   task automatic wait_writes(input string tag, input int n, input int budget);
      int k = 0;
      while (wdat.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk(tag, wdat.size(), n);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_count"}, wdat.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wdat.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), wdat[i], exp_q[i]);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_write"}, write, 0);
      chk({tag, "_active"}, active, 0);
      chk({tag, "_done"}, phrase_done, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_ready"}, req_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_phrase = '0;
      busy_force = 1'b0;
      model_en   = 1'b1;
      tick(2);
      reset_checks("rst");
      rst_n = 1'b1;
      tick(2);

      // Phrase 0 with a 10-cycle busy chatter.
      clear_logs();
      request(0);
      wait_done("t1_done", 1, 300);
      exp_q = {6'h13, 6'h02, 6'h13};
      check_writes("t1");
      chk("t1_active", active, 0);
      if (wcyc.size() == 3 && dcyc.size() == 1) begin
         chk("t1_space", wcyc[1] - wcyc[0], 13);
         chk("t1_done_lat", dcyc[0] - wcyc[2], 11);
      end
      tick(20);
      chk("t1_one_done", dcyc.size(), 1);
      chk("t1_no_extra_wr", wdat.size(), 3);

      // Busy held high while phrase 1 is requested, then released.
      clear_logs();
      busy_force = 1'b1;
      request(1);
      tick(19);
      chk("t2_nowrite", wcyc.size(), 0);
      chk("t2_active", active, 1);
      chk("t2_hold_data", data, 6'h1B);
      rel = ncyc;
      busy_force = 1'b0;
      wait_done("t2_done", 1, 300);
      if (wcyc.size() > 0) chk("t2_first_lat", wcyc[0] - rel, 2);
      exp_q = {6'h1B, 6'h07, 6'h2D, 6'h35};
      check_writes("t2");

      // Chatter never acknowledges: every write rides out the timeout.
      clear_logs();
      model_en = 1'b0;
      request(3);
      wait_done("t3_done", 1, 300);
      exp_q = {6'h2E, 6'h0F, 6'h0B};
      check_writes("t3");
      if (wcyc.size() == 3 && dcyc.size() == 1) begin
         chk("t3_space", wcyc[1] - wcyc[0], 18);
         chk("t3_done_lat", dcyc[0] - wcyc[2], 16);
      end
      model_en = 1'b1;

      // Queue fill and overflow while phrase 5 is stalled on busy.
      clear_logs();
      busy_force = 1'b1;
      request(5);
      tick(4);
      chk("t4_hold_data", data, 6'h1D);
      for (int i = 0; i < 5; i++) begin
         req_valid  = 1'b1;
         req_phrase = 3'(i);
         chk($sformatf("t4_ready%0d", i), req_ready, (i < 4) ? 1 : 0);
         tick(1);
      end
      req_valid = 1'b0;
      chk("t4_ovf", overflow, 1);
      tick(10);
      chk("t4_ovf_sticky", overflow, 1);
      busy_force = 1'b0;
      wait_done("t4_done", 5, 2000);
      exp_q = {6'h1D, 6'h0E, 6'h13,
               6'h13, 6'h02, 6'h13,
               6'h1B, 6'h07, 6'h2D, 6'h35,
               6'h37, 6'h07, 6'h23, 6'h01,
               6'h2E, 6'h0F, 6'h0B};
      check_writes("t4");
      if (wcyc.size() > 3 && dcyc.size() > 0) chk("t4_b2b", wcyc[3] - dcyc[0], 3);
      tick(20);
      chk("t4_ovf_end", overflow, 1);
      chk("t4_idle", active, 0);

      // Phrase 2 queued behind a playing phrase 1.
      clear_logs();
      request(1);
      tick(5);
      request(2);
      wait_done("t6_done", 2, 1000);
      if (wcyc.size() >= 5 && dcyc.size() >= 1) begin
         chk("t6_first_data", wdat[4], 6'h37);
         chk("t6_b2b", wcyc[4] - dcyc[0], 3);
      end

      // Asynchronous reset during WAIT_DONE of the second allophone.
      chk("t5_ovf_pre", overflow, 1);
      clear_logs();
      request(1);
      wait_writes("t5_two", 2, 200);
      tick(3);
      chk("t5_active_pre", active, 1);
      rst_n = 1'b0;
      #1;
      reset_checks("t5_rst");
      tick(2);
      rst_n = 1'b1;
      tick(40);
      chk("t5_nowrite", wdat.size(), 2);
      chk("t5_idle", active, 0);
      clear_logs();
      request(4);
      wait_done("t5_done", 1, 300);
      exp_q = {6'h0D, 6'h1F};
      check_writes("t5_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/phrase_sequencer.md
Name: phrase_sequencer

Overview:
- Queues spoken-phrase requests and plays each one through the chatter speech block.
- For each phrase, walks an internal allophone ROM and feeds the allophones one at a time over chatter's data/write/busy handshake.
- Replaces ad-hoc counter stimulus at the narrator top level: switches, buttons or other logic request phrases by ID and never drive allophones directly.

Parameters:
- NUM_PHRASES, 8, number of phrase IDs; request ID width is clog2(NUM_PHRASES).
- ROM_DEPTH, 64, allophone ROM entries; address width is clog2(ROM_DEPTH).
- QUEUE_DEPTH, 4, phrase request FIFO depth; must be a power of 2.
- ACK_TIMEOUT, 15, maximum cycles to wait for busy to rise after a write pulse.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  phrase request strobe
- req_phrase  input  clog2(NUM_PHRASES)  requested phrase ID
- req_ready  output  1  queue not full; a request is accepted when req_valid && req_ready
- data  output  6  allophone code to chatter
- write  output  1  single-cycle allophone write strobe to chatter
- busy  input  1  chatter busy
- active  output  1  a phrase is in progress
- phrase_done  output  1  one-cycle pulse after the last allophone of a phrase completes
- overflow  output  1  sticky flag; set when req_valid arrives while the queue is full

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE; queue is emptied; data=0, write=0, active=0, phrase_done=0, overflow=0, req_ready=1.
- A reset mid-phrase aborts playback immediately; no further writes are issued.
- ROM entry format: 7 bits; [5:0] is the allophone; [6] is LAST, marking the final allophone of the phrase.
- Start-address table: NUM_PHRASES entries, constant, holding each phrase's start address.
- ROM read latency is 1 cycle, registered.
- FSM states:
  - IDLE: active=0. When the queue is non-empty, pop one entry, load addr=start[id], go to FETCH.
  - FETCH: one cycle for the ROM read; go to ISSUE.
  - ISSUE: hold data=rom[5:0] and latch last=rom[6]. When busy=0, pulse write for one cycle and go to WAIT_ACK. When busy=1, stay.
  - WAIT_ACK: count cycles. When busy=1, go to WAIT_DONE. When the count reaches ACK_TIMEOUT with busy still 0, treat the write as accepted and go to WAIT_DONE.
  - WAIT_DONE: wait for busy=0. Then, if last=1, pulse phrase_done and go to IDLE; otherwise addr+1 and go to FETCH.
- active=1 in every state except IDLE.
- data is stable from the ISSUE entry until the next FETCH.
- Address increment wraps modulo ROM_DEPTH. No error is raised on wrap; guaranteeing LAST markers is the ROM author's responsibility.
- Queue behaviour:
  - Request accepted when req_valid && !full.
  - Push and pop in the same cycle are both honoured when full; when empty, the pushed entry is popped no earlier than the next cycle.
  - Pushing while full drops the request and sets overflow, which stays set until reset.
- Back-to-back phrases: from IDLE with a non-empty queue, the next FETCH follows with no idle gap beyond the pop cycle.
- Minimum spacing between write pulses is 4 cycles: FETCH, ISSUE, WAIT_ACK, WAIT_DONE.

Decomposition:
- Package speech_pkg holds:
  - Allophone code constants (PA1=6'h00, PA2=6'h01, PA3=6'h02, PA4=6'h03, PA5=6'h04, plus named allophones used in the ROM).
  - Bit index of the ROM LAST flag (6).
  - FSM state enum.
  - Phrase start-address table and allophone ROM contents, as constant functions.
- Sub-module phrase_fifo: synchronous FIFO, width clog2(NUM_PHRASES), depth QUEUE_DEPTH, with full/empty outputs and async active-low reset.

Test Plan:
- Phrase 0 = {6'h13, 6'h02, 6'h13|LAST}; chatter model holds busy for 10 cycles after each write → exactly 3 write pulses with data 13, 02, 13; one phrase_done pulse after the third busy fall; then active=0.
- busy held at 1 when phrase 1 is requested, released at cycle 20 → no write before busy falls; first write occurs within 2 cycles of the release.
- Chatter model never raises busy → each write is followed by 15 WAIT_ACK cycles, then sequencing continues; all allophones are issued and phrase_done fires.
- 5 requests in consecutive cycles with busy stuck at 1 → first 4 accepted, req_ready=0 on the 5th, overflow=1 and sticky; phrases play in order 0, 1, 2, 3 after busy is released.
- rst_n pulsed low during the WAIT_DONE of the second allophone → all outputs return to reset values asynchronously; after release no writes occur until a new request arrives.
- Request phrase 2 while phrase 1 is playing → phrase 2's first write follows phrase 1's phrase_done within 4 cycles.
